// File: rtl/image_filter3x3.sv
// 3x3 video filter (bypass / Gaussian / box mean) with two line buffers,
// edge replication and a fixed 4-cycle latency from input timing to output.
module image_filter3x3 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_W  = 1024,
  parameter bit          VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        mode_o,
  output logic              ovf_o
);

  localparam int unsigned COL_W  = $clog2(MAX_W + 1);
  localparam int unsigned AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned ROW_W  = 12;
  localparam int unsigned SUM_W  = DATA_W + 4;
  localparam int unsigned PROD_W = SUM_W + 10;
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              de_prev;
  logic              vs_prev;
  logic              vs_rise;
  logic              col_full;
  logic [AW-1:0]     addr;

  assign vs_rise  = (vsync_i == VS_POL) && (vs_prev != VS_POL);
  assign col_full = (col == COL_W'(MAX_W));
  assign addr     = col_full ? AW'(MAX_W - 1) : AW'(col);

  // Position counters, frame-level mode latch and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      de_prev <= 1'b0;
      vs_prev <= ~VS_POL;
      mode_o  <= 2'd1;
      ovf_o   <= 1'b0;
    end else begin
      de_prev <= de_i;
      vs_prev <= vsync_i;
      if (de_i) begin
        if (!col_full) col <= col + COL_W'(1);
      end else if (de_prev) begin
        col <= '0;
      end
      if (vs_rise) begin
        row <= '0;
      end else if (de_prev && !de_i && (row != '1)) begin
        row <= row + ROW_W'(1);
      end
      if (vs_rise) mode_o <= (mode_i == 2'd3) ? 2'd1 : mode_i;
      if (de_i && col_full) begin
        ovf_o <= 1'b1;
      end else if (vs_rise) begin
        ovf_o <= 1'b0;
      end
    end
  end

  logic [DATA_W-1:0] lb1 [MAX_W];
  logic [DATA_W-1:0] lb2 [MAX_W];
  logic [DATA_W-1:0] s1_up1;
  logic [DATA_W-1:0] s1_up2;

  // Line buffers: lb1 holds the previous row, lb2 the one before; reads see pre-write data
  always_ff @(posedge clk) begin
    s1_up1 <= lb1[addr];
    s1_up2 <= lb2[addr];
    if (de_i && !col_full) begin
      lb1[addr] <= data_i;
      lb2[addr] <= lb1[addr];
    end
  end

  logic              s1_vld;
  logic [DATA_W-1:0] s1_raw;
  logic              s1_r1;
  logic              s1_r2;
  logic              s1_first;
  logic              s1_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_raw   <= '0;
      s1_r1    <= 1'b0;
      s1_r2    <= 1'b0;
      s1_first <= 1'b0;
      s1_full  <= 1'b0;
    end else begin
      s1_vld   <= de_i;
      s1_raw   <= data_i;
      s1_r1    <= (row != '0);
      s1_r2    <= (row >= ROW_W'(2));
      s1_first <= (col == '0);
      s1_full  <= col_full;
    end
  end

  // Vertical edge replication: missing upper rows reuse the nearest real row
  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;
  logic [DATA_W-1:0] col_bot;

  always_comb begin
    col_bot = s1_raw;
    col_mid = s1_r1 ? s1_up1 : s1_raw;
    col_top = s1_r2 ? s1_up2 : col_mid;
  end

  logic [DATA_W-1:0] w_t [3];
  logic [DATA_W-1:0] w_m [3];
  logic [DATA_W-1:0] w_b [3];
  logic [DATA_W-1:0] s2_raw;

  // Window shift: index 2 is newest; column 0 fills the whole window, overflow freezes the newest column
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        w_t[i] <= '0;
        w_m[i] <= '0;
        w_b[i] <= '0;
      end
      s2_raw <= '0;
    end else begin
      s2_raw <= s1_raw;
      if (s1_vld) begin
        w_t[0] <= s1_first ? col_top : w_t[1];
        w_m[0] <= s1_first ? col_mid : w_m[1];
        w_b[0] <= s1_first ? col_bot : w_b[1];
        w_t[1] <= s1_first ? col_top : w_t[2];
        w_m[1] <= s1_first ? col_mid : w_m[2];
        w_b[1] <= s1_first ? col_bot : w_b[2];
        if (!s1_full) begin
          w_t[2] <= col_top;
          w_m[2] <= col_mid;
          w_b[2] <= col_bot;
        end
      end
    end
  end

  logic [SUM_W-1:0]  g_sum;
  logic [SUM_W-1:0]  b_sum;
  logic [PROD_W-1:0] b_prod;
  logic [PROD_W-1:0] b_q;
  logic [DATA_W-1:0] g_res;
  logic [DATA_W-1:0] b_res;

  always_comb begin
    g_sum  = SUM_W'(w_t[0]) + (SUM_W'(w_t[1]) << 1) + SUM_W'(w_t[2])
           + (SUM_W'(w_m[0]) << 1) + (SUM_W'(w_m[1]) << 2) + (SUM_W'(w_m[2]) << 1)
           + SUM_W'(w_b[0]) + (SUM_W'(w_b[1]) << 1) + SUM_W'(w_b[2]);
    b_sum  = SUM_W'(w_t[0]) + SUM_W'(w_t[1]) + SUM_W'(w_t[2])
           + SUM_W'(w_m[0]) + SUM_W'(w_m[1]) + SUM_W'(w_m[2])
           + SUM_W'(w_b[0]) + SUM_W'(w_b[1]) + SUM_W'(w_b[2]);
    // Divide by 9 approximated as *455/4096 with rounding
    b_prod = PROD_W'(b_sum) * PROD_W'(455) + PROD_W'(2048);
    b_q    = b_prod >> 12;
    g_res  = DATA_W'((g_sum + SUM_W'(8)) >> 4);
    b_res  = (b_q > PROD_W'(PIX_MAX)) ? PIX_MAX : DATA_W'(b_q);
  end

  logic [DATA_W-1:0] res;
  logic [2:0]        hs_d;
  logic [2:0]        vs_d;
  logic [2:0]        de_d;

  // Result select, timing delay line and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      hs_d    <= '0;
      vs_d    <= {3{~VS_POL}};
      de_d    <= '0;
      hsync_o <= 1'b0;
      vsync_o <= ~VS_POL;
      de_o    <= 1'b0;
      data_o  <= '0;
    end else begin
      case (mode_o)
        2'd0:    res <= s2_raw;
        2'd2:    res <= b_res;
        default: res <= g_res;
      endcase
      hs_d    <= {hs_d[1:0], hsync_i};
      vs_d    <= {vs_d[1:0], vsync_i};
      de_d    <= {de_d[1:0], de_i};
      hsync_o <= hs_d[2];
      vsync_o <= vs_d[2];
      de_o    <= de_d[2];
      data_o  <= de_d[2] ? res : '0;
    end
  end

endmodule

// File: tb/tb_image_filter3x3.sv
// Self-checking bench for image_filter3x3: table of frame cases with probe values,
// random frames against a window-level reference model, and reset/overflow sequences.
module tb_image_filter3x3;

  localparam int DW   = 8;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode_i = 2'd0;
  logic          hsync_i = 1'b0;
  logic          vsync_i = 1'b0;
  logic          de_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          hsync_o, vsync_o, de_o, ovf_o;
  logic [DW-1:0] data_o;
  logic [1:0]    mode_o;

  image_filter3x3 #(.DATA_W(DW), .MAX_W(MAXW), .VS_POL(1'b1)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .data_i(data_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .data_o(data_o),
    .mode_o(mode_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected model state, updated by the stimulus process after each sampling edge
  int mode_m = 1;
  int ovf_m  = 0;
  int pix [8][12];
  int got_q [$];
  int exp_q [$];

  // Timing history: index 0 is the most recent sample taken by the DUT
  bit hs_h [4] = '{0, 0, 0, 0};
  bit vs_h [4] = '{0, 0, 0, 0};
  bit de_h [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hs_h[i] = 1'b0; vs_h[i] = 1'b0; de_h[i] = 1'b0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        hs_h[i] = hs_h[i-1]; vs_h[i] = vs_h[i-1]; de_h[i] = de_h[i-1];
      end
      hs_h[0] = hsync_i; vs_h[0] = vsync_i; de_h[0] = de_i;
    end
  end

  always @(negedge clk) begin
    chk("hsync_o", int'(hsync_o), int'(hs_h[3]));
    chk("vsync_o", int'(vsync_o), int'(vs_h[3]));
    chk("de_o",    int'(de_o),    int'(de_h[3]));
    chk("mode_o",  int'(mode_o),  mode_m);
    chk("ovf_o",   int'(ovf_o),   ovf_m);
    if (de_o) got_q.push_back(int'(data_o));
    else chk("data_o_idle", int'(data_o), 0);
  end

  // Reference: 3x3 window ending at (r,c), rows clamped at 0, columns clamped to [0, MAXW-1]
  function automatic int model_px(input int r, input int c, input int m);
    int acc, rr, cc, wgt, q;
    if (m == 0) return pix[r][c];
    acc = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r - 2 + dr;
        cc = c - 2 + dc;
        if (rr < 0) rr = 0;
        if (cc < 0) cc = 0;
        if (cc > MAXW - 1) cc = MAXW - 1;
        wgt = (m == 2) ? 1 : (((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1));
        acc += wgt * pix[rr][cc];
      end
    end
    if (m == 2) begin
      q = (acc * 455 + 2048) / 4096;
      return (q > 255) ? 255 : q;
    end
    return (acc + 8) / 16;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic vsync_pulse(input int fm);
    vsync_i = 1'b1;
    cyc();
    ovf_m  = 0;
    mode_m = fm;
    cyc();
    vsync_i = 1'b0;
    idle(3);
  endtask

  // pat: 0 flat 100, 1 dot at (2,2), 2 dot at (0,0), 3 random, 4 column ramp
  task automatic run_frame(input int mreq, input int w, input int h, input int pat,
                           input int mid, input int pr, input int pc, output int probe);
    int fm, n;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (pat)
          0: pix[r][c] = 100;
          1: pix[r][c] = (r == 2 && c == 2) ? 255 : 0;
          2: pix[r][c] = (r == 0 && c == 0) ? 255 : 0;
          3: pix[r][c] = int'($urandom_range(0, 255));
          default: pix[r][c] = c * 10;
        endcase
    fm = (mreq == 3) ? 1 : mreq;
    mode_i = 2'(mreq);
    idle(2);
    got_q.delete();
    exp_q.delete();
    vsync_pulse(fm);
    for (int r = 0; r < h; r++) begin
      hsync_i = 1'b1; cyc(); hsync_i = 1'b0; cyc();
      if (mid >= 0 && r == 1) mode_i = 2'(mid);
      for (int c = 0; c < w; c++) begin
        de_i = 1'b1;
        data_i = DW'(pix[r][c]);
        exp_q.push_back(model_px(r, c, fm));
        cyc();
        if (c >= MAXW) ovf_m = 1;
      end
      de_i = 1'b0;
      data_i = '0;
      idle(6);
    end
    idle(8);
    chk("out_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("pix_r%0d_c%0d", i / w, i % w), got_q[i], exp_q[i]);
    probe = (pr * w + pc < got_q.size()) ? got_q[pr * w + pc] : -1;
  endtask

  typedef struct {
    int mode; int w; int h; int pat; int mid; int pr; int pc; int exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int pv;
    tbl[0]  = '{1, 8, 4, 0, -1, 3, 7, 100};
    tbl[1]  = '{1, 8, 4, 0, -1, 0, 0, 100};
    tbl[2]  = '{2, 8, 4, 1, -1, 2, 2, 28};
    tbl[3]  = '{2, 8, 4, 1, -1, 3, 4, 28};
    tbl[4]  = '{2, 8, 4, 1, -1, 2, 1, 0};
    tbl[5]  = '{1, 8, 4, 2, -1, 0, 0, 255};
    tbl[6]  = '{1, 8, 4, 2, -1, 2, 2, 16};
    tbl[7]  = '{1, 8, 4, 2, -1, 1, 1, 143};
    tbl[8]  = '{1, 8, 4, 2, -1, 0, 1, 191};
    tbl[9]  = '{2, 8, 4, 2, -1, 0, 0, 255};
    tbl[10] = '{0, 8, 4, 3,  2, 1, 3, -1};
    tbl[11] = '{2, 8, 4, 0, -1, 2, 5, 100};
    tbl[12] = '{1, 10, 2, 4, -1, 0, 9, 70};
    tbl[13] = '{1, 10, 2, 4, -1, 0, 8, 68};
    tbl[14] = '{3, 6, 3, 0, -1, 2, 3, 100};
    tbl[15] = '{1, 8, 4, 3, -1, 3, 3, -1};

    idle(3);
    rst = 1'b0;
    chk("rst_data_o", int'(data_o), 0);
    chk("rst_vsync_o", int'(vsync_o), 0);
    chk("rst_mode_o", int'(mode_o), 1);
    chk("rst_ovf_o", int'(ovf_o), 0);
    idle(2);

    for (int i = 0; i < 16; i++) begin
      run_frame(tbl[i].mode, tbl[i].w, tbl[i].h, tbl[i].pat, tbl[i].mid,
                tbl[i].pr, tbl[i].pc, pv);
      if (tbl[i].exp >= 0) chk($sformatf("probe%0d", i), pv, tbl[i].exp);
      if (tbl[i].mid >= 0) chk("mode_held_mid_frame", int'(mode_o), tbl[i].mode);
      if (tbl[i].w > MAXW) chk("ovf_after_long_line", int'(ovf_o), 1);
    end

    for (int k = 0; k < 5; k++)
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(3, 8)),
                int'($urandom_range(2, 6)), 3, -1, 0, 0, pv);

    // Reset in the middle of a line, then a flat frame must reproduce the golden output
    mode_i = 2'd1;
    vsync_pulse(1);
    hsync_i = 1'b1; cyc(); hsync_i = 1'b0; cyc();
    for (int c = 0; c < 4; c++) begin
      de_i = 1'b1; data_i = DW'(100); cyc();
    end
    rst = 1'b1;
    cyc();
    mode_m = 1;
    ovf_m = 0;
    rst = 1'b0;
    de_i = 1'b0;
    data_i = '0;
    chk("midrst_de_o", int'(de_o), 0);
    chk("midrst_data_o", int'(data_o), 0);
    chk("midrst_vsync_o", int'(vsync_o), 0);
    chk("midrst_hsync_o", int'(hsync_o), 0);
    chk("midrst_mode_o", int'(mode_o), 1);
    idle(4);
    run_frame(1, 8, 4, 0, -1, 3, 7, pv);
    chk("post_rst_probe", pv, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 400000");
    $fatal(1);
  end

endmodule
